// File: rtl/spi_accel_burst_reader.sv
// spi_accel_burst_reader: SPI mode-0 master reading NUM_REGS consecutive registers per frame
module spi_accel_burst_reader #(
  parameter int CLK_DIV = 2,
  parameter int NUM_REGS = 3,
  parameter logic [7:0] READ_CMD = 8'h0B,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cont_en,
  input  logic [7:0]            start_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  byte_valid,
  output logic [2:0]            byte_index,
  output logic [7:0]            byte_data,
  output logic [8*NUM_REGS-1:0] rx_data,
  output logic                  sclk,
  output logic                  ss_n,
  output logic                  mosi,
  input  logic                  miso
);
  localparam int NBITS = 16 + 8 * NUM_REGS;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [6:0] BIT_LAST = 7'(NBITS - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [15:0] cnt;
  logic [6:0] bit_cnt;
  logic [15:0] tx;
  logic [7:0] rx;
  logic [8*NUM_REGS-1:0] shadow;
  logic accept, div_tc, rise, fall, last_bit, data_end, hold_end;
  logic [2:0] idx;
  logic [7:0] rx_byte;
  assign accept = state == IDLE && (start || cont_en);
  assign div_tc = cnt == DIV_LAST;
  assign rise = state == SHIFT && div_tc && !sclk;
  assign fall = state == SHIFT && div_tc && sclk;
  assign last_bit = bit_cnt == BIT_LAST;
  assign hold_end = state == HOLD && div_tc;
  assign data_end = rise && bit_cnt >= 7'd16 && bit_cnt[2:0] == 3'd7;
  assign idx = 3'((bit_cnt - 7'd16) >> 3);
  assign rx_byte = {rx[6:0], miso};
  assign busy = state != IDLE;
  // the transmit register's MSB is the mosi flop; it empties to zero during data bytes
  assign mosi = tx[15];
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? SETUP : IDLE;
      SETUP:   state_n = div_tc ? SHIFT : SETUP;
      SHIFT:   state_n = fall && last_bit ? HOLD : SHIFT;
      HOLD:    state_n = div_tc ? GAP : HOLD;
      GAP:     state_n = cnt == GAP_LAST ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      bit_cnt <= '0;
      tx <= '0;
      rx <= '0;
      shadow <= '0;
      sclk <= 1'b0;
      ss_n <= 1'b1;
      done <= 1'b0;
      byte_valid <= 1'b0;
      byte_index <= '0;
      byte_data <= '0;
      rx_data <= '0;
    end else begin
      cnt <= (state_n != state || state == IDLE || rise || fall) ? '0 : cnt + 16'd1;
      done <= hold_end;
      byte_valid <= data_end;
      if (accept) begin
        tx <= {READ_CMD, start_addr};
        bit_cnt <= '0;
        ss_n <= 1'b0;
      end
      if (rise) begin
        sclk <= 1'b1;
        rx <= rx_byte;
      end
      if (fall) begin
        sclk <= 1'b0;
        tx <= {tx[14:0], 1'b0};
        bit_cnt <= bit_cnt + 7'd1;
      end
      if (data_end) begin
        shadow[8*idx +: 8] <= rx_byte;
        byte_index <= idx;
        byte_data <= rx_byte;
      end
      if (hold_end) begin
        ss_n <= 1'b1;
        rx_data <= shadow;
      end
    end
  end
endmodule

// File: tb/tb_spi_accel_burst_reader.sv
// tb_spi_accel_burst_reader: randomized bench with behavioural SPI slaves and a frame-level reference model
module tb_spi_accel_burst_reader;
  localparam int FRAME = 2 * (2 + 2 * 40);
  localparam int LAT = 1 + FRAME;
  localparam int GAP = 4;
  logic clk = 0, reset = 1, start = 0, cont_en = 0, miso;
  logic [7:0] start_addr = 0;
  logic busy, done, byte_valid, sclk, ss_n, mosi;
  logic [2:0] byte_index;
  logic [7:0] byte_data;
  logic [23:0] rx_data;
  logic start_b = 0, cont_b = 0, miso_b;
  logic [7:0] addr_b = 8'h20;
  logic busy_b, done_b, bv_b, sclk_b, ss_n_b, mosi_b;
  logic [2:0] bi_b;
  logic [7:0] bd_b, rx_b;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [23:0] exp_rx = 0;
  logic [7:0] sdata [3];
  logic [7:0] sdata_b = 0;
  logic [7:0] sbyte;
  int sinc = 0, sbit = 0, fcnt = 0, sbit_b = 0;
  logic sclk_q = 0, ssn_q = 1, sclkb_q = 0;

  spi_accel_burst_reader #(.CLK_DIV(2), .NUM_REGS(3), .READ_CMD(8'h0B), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .cont_en(cont_en), .start_addr(start_addr),
    .busy(busy), .done(done), .byte_valid(byte_valid), .byte_index(byte_index),
    .byte_data(byte_data), .rx_data(rx_data), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso));

  spi_accel_burst_reader #(.CLK_DIV(1), .NUM_REGS(1), .READ_CMD(8'h0B), .GAP_CYCLES(1)) dut_min (
    .clk(clk), .reset(reset), .start(start_b), .cont_en(cont_b), .start_addr(addr_b),
    .busy(busy_b), .done(done_b), .byte_valid(bv_b), .byte_index(bi_b),
    .byte_data(bd_b), .rx_data(rx_b), .sclk(sclk_b), .ss_n(ss_n_b), .mosi(mosi_b), .miso(miso_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // slaves count sclk rises within a frame and present the next bit before the master samples it
  always @(negedge clk) begin
    sclk_q <= sclk;
    ssn_q <= ss_n;
    sclkb_q <= sclk_b;
    if (ss_n) sbit <= 0;
    else if (sclk && !sclk_q) sbit <= sbit + 1;
    if (!ss_n && ssn_q) fcnt <= fcnt + 1;
    if (ss_n_b) sbit_b <= 0;
    else if (sclk_b && !sclkb_q) sbit_b <= sbit_b + 1;
  end

  always_comb begin
    sbyte = 8'h00;
    if (sbit >= 16 && sbit < 40) sbyte = sdata[(sbit - 16) / 8] + 8'(sinc * fcnt);
    miso = (sbit >= 16 && sbit < 40) ? sbyte[7 - (sbit - 16) % 8] : 1'b0;
  end
  assign miso_b = (sbit_b >= 16 && sbit_b < 24) ? sdata_b[7 - (sbit_b - 16)] : 1'b0;

  function automatic logic [23:0] frame_data(int f);
    return {sdata[2] + 8'(sinc * f), sdata[1] + 8'(sinc * f), sdata[0] + 8'(sinc * f)};
  endfunction

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ss_n, sclk, mosi, busy, done, byte_valid} !== 6'b100000 || rx_data !== 24'h0) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: ss_n=%b sclk=%b mosi=%b busy=%b done=%b bv=%b rx=%h, want 1 0 0 0 0 0 rx=000000",
                 i, ss_n, sclk, mosi, busy, done, byte_valid, rx_data);
      end
    end
  endtask

  task automatic test_burst(input logic [7:0] addr, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int t0, got, nb, nv, ones, part;
    logic ps;
    logic [7:0] cmd, ad;
    logic [7:0] wb [3];
    logic [23:0] want;
    sdata[0] = b0; sdata[1] = b1; sdata[2] = b2; sinc = 0;
    wb[0] = b0; wb[1] = b1; wb[2] = b2;
    want = {b2, b1, b0};
    got = -1; nb = 0; nv = 0; ones = 0; part = 0; ps = 0; cmd = 0; ad = 0;
    @(posedge clk); #1 start_addr = addr; start = 1; t0 = cyc;
    @(posedge clk); #1 start = 0; start_addr = 8'($urandom);
    for (int i = 0; i < 400 && got < 0; i++) begin
      @(negedge clk);
      if (sclk && !ps) begin
        nb++;
        if (nb <= 8) cmd = {cmd[6:0], mosi};
        else if (nb <= 16) ad = {ad[6:0], mosi};
        else ones += int'(mosi);
      end
      ps = sclk;
      if (byte_valid) begin
        n_cmp++;
        if (nv > 2) begin
          n_bad++; $display("FAIL burst_extra_byte: index %0d data %h, want no more than 3 bytes", byte_index, byte_data);
        end else if (byte_index !== 3'(nv) || byte_data !== wb[nv]) begin
          n_bad++; $display("FAIL burst_byte: got idx %0d data %h, want idx %0d data %h", byte_index, byte_data, nv, wb[nv]);
        end
        nv++;
      end
      if (done) got = cyc - t0;
      else if (rx_data !== exp_rx) part++;
    end
    n_cmp++; if (got != LAT) begin n_bad++; $display("FAIL burst_latency: got %0d want %0d", got, LAT); end
    n_cmp++; if (rx_data !== want) begin n_bad++; $display("FAIL burst_rx: got %h want %h", rx_data, want); end
    n_cmp++; if (part != 0) begin n_bad++; $display("FAIL burst_atomic: rx_data changed early in %0d cycles, want 0", part); end
    n_cmp++; if (cmd !== 8'h0B) begin n_bad++; $display("FAIL burst_cmd: got %h want 0b", cmd); end
    n_cmp++; if (ad !== addr) begin n_bad++; $display("FAIL burst_addr: got %h want %h", ad, addr); end
    n_cmp++; if (nb != 40) begin n_bad++; $display("FAIL burst_sclk_pulses: got %0d want 40", nb); end
    n_cmp++; if (ones != 0) begin n_bad++; $display("FAIL burst_mosi_data: %0d ones, want 0", ones); end
    n_cmp++; if (nv != 3) begin n_bad++; $display("FAIL burst_byte_count: got %0d want 3", nv); end
    exp_rx = want;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ss_n !== 1'b1) begin n_bad++; $display("FAIL burst_idle: busy=%b ss_n=%b want 0 1", busy, ss_n); end
  endtask

  task automatic test_min_config(input logic [7:0] b);
    int t0, got, hi, nr, nv;
    logic ps;
    logic [7:0] bd;
    sdata_b = b;
    got = -1; hi = 0; nr = 0; nv = 0; ps = 0; bd = 0;
    @(posedge clk); #1 start_b = 1; t0 = cyc;
    @(posedge clk); #1 start_b = 0;
    for (int i = 0; i < 100 && got < 0; i++) begin
      @(negedge clk);
      if (sclk_b) hi++;
      if (sclk_b && !ps) nr++;
      ps = sclk_b;
      if (bv_b) begin nv++; bd = bd_b; end
      if (done_b) got = cyc - t0;
    end
    n_cmp++; if (got != 51) begin n_bad++; $display("FAIL min_latency: got %0d want 51", got); end
    n_cmp++; if (rx_b !== b) begin n_bad++; $display("FAIL min_rx: got %h want %h", rx_b, b); end
    n_cmp++; if (hi != 24 || nr != 24) begin n_bad++; $display("FAIL min_sclk: high cycles %0d pulses %0d, want 24 24", hi, nr); end
    n_cmp++; if (nv != 1 || bd !== b) begin n_bad++; $display("FAIL min_byte: count %0d data %h, want 1 %h", nv, bd, b); end
  endtask

  task automatic test_continuous;
    int t0, k, f0, extra;
    int d [3];
    logic [23:0] want;
    sdata[0] = 8'h00; sdata[1] = 8'($urandom); sdata[2] = 8'($urandom); sinc = 1;
    f0 = fcnt; k = 0; extra = 0;
    @(posedge clk); #1 cont_en = 1; t0 = cyc;
    for (int i = 0; i < 700 && k < 3; i++) begin
      @(negedge clk);
      if (done) begin
        d[k] = cyc - t0;
        want = frame_data(f0 + k + 1);
        n_cmp++; if (rx_data !== want) begin n_bad++; $display("FAIL cont_rx frame %0d: got %h want %h", k, rx_data, want); end
        k++;
      end
    end
    n_cmp++;
    if (k != 3) begin
      n_bad++; $display("FAIL cont_done_count: got %0d want 3", k);
    end else begin
      if (d[0] != LAT) begin n_bad++; $display("FAIL cont_first: got %0d want %0d", d[0], LAT); end
      n_cmp++; if (d[1] - d[0] != FRAME + GAP + 1) begin n_bad++; $display("FAIL cont_spacing1: got %0d want %0d", d[1] - d[0], FRAME + GAP + 1); end
      n_cmp++; if (d[2] - d[1] != FRAME + GAP + 1) begin n_bad++; $display("FAIL cont_spacing2: got %0d want %0d", d[2] - d[1], FRAME + GAP + 1); end
    end
    repeat (60) @(negedge clk);
    cont_en = 0;
    want = frame_data(f0 + 4);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done) begin
        extra++;
        n_cmp++; if (rx_data !== want) begin n_bad++; $display("FAIL cont_last_rx: got %h want %h", rx_data, want); end
      end
    end
    n_cmp++; if (extra != 1) begin n_bad++; $display("FAIL cont_stop: got %0d more done, want 1", extra); end
    n_cmp++; if (busy !== 1'b0 || ss_n !== 1'b1) begin n_bad++; $display("FAIL cont_idle: busy=%b ss_n=%b want 0 1", busy, ss_n); end
    exp_rx = want;
    sinc = 0;
  endtask

  task automatic test_start_busy;
    int t0, m, dn, nd, f0;
    logic [23:0] want;
    for (int i = 0; i < 3; i++) sdata[i] = 8'($urandom);
    sinc = 0; want = frame_data(0); f0 = fcnt; dn = -1; nd = 0;
    @(posedge clk); #1 start = 1; t0 = cyc;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      m = cyc - t0;
      start = (m == 30);
      if (done) begin nd++; if (dn < 0) dn = m; end
      if (dn >= 0 && m == dn + GAP - 1) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_gap: got %b want 1", busy); end
      end
      if (dn >= 0 && m == dn + GAP) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_gap: got %b want 0", busy); end
      end
    end
    start = 0;
    n_cmp++; if (fcnt - f0 != 1) begin n_bad++; $display("FAIL busy_frames: ss_n fell %0d times, want 1", fcnt - f0); end
    n_cmp++; if (nd != 1 || dn != LAT) begin n_bad++; $display("FAIL busy_done: count %0d at %0d, want 1 at %0d", nd, dn, LAT); end
    n_cmp++; if (rx_data !== want) begin n_bad++; $display("FAIL busy_rx: got %h want %h", rx_data, want); end
    exp_rx = want;
  endtask

  task automatic test_start_and_cont;
    int nd, f0;
    f0 = fcnt; nd = 0;
    @(posedge clk); #1 start = 1; cont_en = 1;
    @(posedge clk); #1 start = 0; cont_en = 0;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_cmp++; if (fcnt - f0 != 1 || nd != 1) begin n_bad++; $display("FAIL start_cont: frames %0d done %0d, want 1 1", fcnt - f0, nd); end
    n_cmp++; if (rx_data !== frame_data(0)) begin n_bad++; $display("FAIL start_cont_rx: got %h want %h", rx_data, frame_data(0)); end
    exp_rx = frame_data(0);
  endtask

  task automatic test_reset_mid_frame;
    int t0, nd, nv;
    nd = 0; nv = 0;
    @(posedge clk); #1 start = 1; t0 = cyc;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 200 && cyc - t0 < 44; i++) begin
      @(negedge clk);
      nd += int'(done); nv += int'(byte_valid);
    end
    reset = 1;
    @(negedge clk);
    n_cmp++; if (ss_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin n_bad++; $display("FAIL abort_pins: ss_n=%b sclk=%b mosi=%b want 1 0 0", ss_n, sclk, mosi); end
    n_cmp++; if (rx_data !== 24'h0) begin n_bad++; $display("FAIL abort_rx: got %h want 000000", rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    reset = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      nd += int'(done); nv += int'(byte_valid);
    end
    n_cmp++; if (nd != 0 || nv != 0) begin n_bad++; $display("FAIL abort_pulses: done %0d byte_valid %0d, want 0 0", nd, nv); end
    exp_rx = 24'h0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) sdata[i] = 8'h00;
    test_reset;
    test_burst(8'h08, 8'h12, 8'hA5, 8'hFF);
    test_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    test_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    test_min_config(8'h3C);
    test_min_config(8'($urandom));
    test_continuous;
    test_start_busy;
    test_start_and_cont;
    test_reset_mid_frame;
    test_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
